// File: rtl/vol_pkg.sv
// Shared types and default timing constants for the volume pushbutton controller.
package vol_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UP_HOLD  = 2'd1,
        DWN_HOLD = 2'd2,
        LOCK     = 2'd3
    } vol_state_e;

    localparam int unsigned DEF_DEB_CNT = 500000;
    localparam int unsigned DEF_RPT_DLY = 25000000;
    localparam int unsigned DEF_RPT_PER = 5000000;

    // Bits needed to hold values 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vol_debounce.sv
// Two-flop synchronizer followed by a stability-window debouncer for one raw button.
module vol_debounce
    import vol_pkg::*;
#(
    parameter int unsigned DEB_CNT = DEF_DEB_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_deb
);

    localparam int unsigned CW = cnt_w(DEB_CNT);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // Counter runs only while the synchronized input disagrees with the debounced value.
    always_comb begin
        sync_d = {sync_q[0], btn_raw};
        cnt_d  = '0;
        deb_d  = deb_q;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CW'(DEB_CNT - 1)) begin
                deb_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign btn_deb = deb_q;

endmodule

// File: rtl/vol_btn_ctrl.sv
// Volume up/down pushbutton controller: debounce, press arbitration, single-cycle step pulses.
// Optional auto-repeat while a single button is held: define VOL_AUTO_REPEAT_EN.
module vol_btn_ctrl
    import vol_pkg::*;
#(
    parameter int unsigned DEB_CNT = DEF_DEB_CNT,
    parameter int unsigned RPT_DLY = DEF_RPT_DLY,
    parameter int unsigned RPT_PER = DEF_RPT_PER
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dwn,
    output logic step_up,
    output logic step_dwn
);

    if (DEB_CNT == 0 || RPT_DLY == 0 || RPT_PER == 0) begin : g_bad_param
        $error("vol_btn_ctrl: DEB_CNT, RPT_DLY and RPT_PER must be nonzero");
    end

    logic       up_deb, dwn_deb;
    vol_state_e state_q, state_d;
    logic       step_up_q, step_up_d;
    logic       step_dwn_q, step_dwn_d;

    vol_debounce #(.DEB_CNT(DEB_CNT)) u_deb_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_up),
        .btn_deb (up_deb)
    );

    vol_debounce #(.DEB_CNT(DEB_CNT)) u_deb_dwn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_dwn),
        .btn_deb (dwn_deb)
    );

`ifdef VOL_AUTO_REPEAT_EN
    localparam int unsigned TW = cnt_w((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER);
    logic [TW-1:0] tmr_q, tmr_d;
`endif

    // In IDLE a high debounced level is always a fresh press: every path back to IDLE needs it low.
    always_comb begin
        state_d    = state_q;
        step_up_d  = 1'b0;
        step_dwn_d = 1'b0;
`ifdef VOL_AUTO_REPEAT_EN
        tmr_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                if (up_deb && dwn_deb) begin
                    state_d = LOCK;
                end else if (up_deb) begin
                    state_d   = UP_HOLD;
                    step_up_d = 1'b1;
`ifdef VOL_AUTO_REPEAT_EN
                    tmr_d     = TW'(RPT_DLY - 1);
`endif
                end else if (dwn_deb) begin
                    state_d    = DWN_HOLD;
                    step_dwn_d = 1'b1;
`ifdef VOL_AUTO_REPEAT_EN
                    tmr_d      = TW'(RPT_DLY - 1);
`endif
                end
            end
            UP_HOLD, DWN_HOLD: begin
                if ((state_q == UP_HOLD) ? !up_deb : !dwn_deb) begin
                    state_d = IDLE;
                end else if ((state_q == UP_HOLD) ? dwn_deb : up_deb) begin
                    state_d = LOCK;
                end else begin
`ifdef VOL_AUTO_REPEAT_EN
                    if (tmr_q == '0) begin
                        step_up_d  = (state_q == UP_HOLD);
                        step_dwn_d = (state_q == DWN_HOLD);
                        tmr_d      = TW'(RPT_PER - 1);
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
`endif
                end
            end
            LOCK: begin
                if (!up_deb && !dwn_deb) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_up_q  <= 1'b0;
            step_dwn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_up_q  <= step_up_d;
            step_dwn_q <= step_dwn_d;
        end
    end

`ifdef VOL_AUTO_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    assign step_up  = step_up_q;
    assign step_dwn = step_dwn_q;

endmodule
